// File: rtl/out_uart_tx.sv
// out_uart_tx: queues each OUT register change and sends it as 8N1 UART frames.
// Define OUT_UART_ASCII_HEX_EN to send each value as ASCII hex digits plus CR LF.
module out_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         out_val,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] last_val;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;
  logic [CW-1:0]         baud, baud_n;
  logic [2:0]            bit_idx, bit_idx_n;
  logic [7:0]            shift, shift_n;
  logic                  change, push, pop;
  logic                  bit_end, tx_n;

`ifdef OUT_UART_ASCII_HEX_EN
  logic [1:0] char_idx, char_idx_n;
  logic [7:0] val_q, val_n;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n > 4'd9) ? ({4'h0, n} + 8'd55) : ({4'h0, n} + 8'd48);
  endfunction

  function automatic logic [7:0] ascii_char(input logic [7:0] v,
                                            input logic [1:0] i);
    case (i)
      2'd0:    return hex_char(v[7:4]);
      2'd1:    return hex_char(v[3:0]);
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction
`endif

  assign change       = (out_val != last_val);
  assign push         = change && (count < DEPTH_C);
  assign bit_end      = (baud == LAST_C);
  assign fifo_count_o = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_val   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (change) last_val <= out_val;
      if (change && !push) overflow_o <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= out_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
`ifdef OUT_UART_ASCII_HEX_EN
      char_idx <= '0;
      val_q    <= '0;
`endif
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_o    <= tx_n;
`ifdef OUT_UART_ASCII_HEX_EN
      char_idx <= char_idx_n;
      val_q    <= val_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
`ifdef OUT_UART_ASCII_HEX_EN
    char_idx_n = char_idx;
    val_n      = val_q;
`endif
    unique case (state)
      IDLE: begin
        baud_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          state_n = START;
`ifdef OUT_UART_ASCII_HEX_EN
          val_n      = mem[rd_ptr];
          char_idx_n = '0;
          shift_n    = ascii_char(mem[rd_ptr], 2'd0);
`else
          shift_n = mem[rd_ptr];
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
`ifdef OUT_UART_ASCII_HEX_EN
        // Stop bit stretched by one cycle between characters of one value
        if (char_idx == 2'd3) begin
          if (bit_end) state_n = IDLE;
        end else if (baud == CW'(CLKS_PER_BIT)) begin
          state_n    = START;
          baud_n     = '0;
          char_idx_n = char_idx + 2'd1;
          shift_n    = ascii_char(val_q, char_idx + 2'd1);
        end
`else
        if (bit_end) state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tx_n = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
    busy_o = (state != IDLE) || (count != '0);
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: checks out_uart_tx against a line-level frame model.
// Define OUT_UART_ASCII_HEX_EN to exercise the ASCII hex build.
module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] out_val = 8'h00;
  logic       tx_o, busy_o, overflow_o;
  logic [2:0] fifo_count_o;

  out_uart_tx #(
    .DATA_WIDTH(8),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .out_val(out_val),
    .tx_o(tx_o),
    .busy_o(busy_o),
    .overflow_o(overflow_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: pending values plus the exact tx level for every upcoming cycle
  logic [7:0] m_q[$];
  logic       m_line[$];
  logic [7:0] m_last;
  logic       m_ovf;
  logic       started = 1'b0;
  logic       saw_low;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return 8'h41 + {4'h0, n} - 8'd10;
  endfunction

  task automatic sched_byte(input logic [7:0] b);
    repeat (CPB) m_line.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (CPB) m_line.push_back(b[k]);
    repeat (CPB) m_line.push_back(1'b1);
  endtask

  task automatic sched_value(input logic [7:0] v);
`ifdef OUT_UART_ASCII_HEX_EN
    logic [7:0] chars [4];
    chars[0] = hex_ascii(v[7:4]);
    chars[1] = hex_ascii(v[3:0]);
    chars[2] = 8'h0D;
    chars[3] = 8'h0A;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) m_line.push_back(1'b1);
      sched_byte(chars[c]);
    end
`else
    sched_byte(v);
`endif
  endtask

  task automatic model_step();
    int         pre;
    logic       line_idle;
    logic [7:0] v;
    if (reset) begin
      m_q.delete();
      m_line.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
      return;
    end
    pre       = m_q.size();
    line_idle = (m_line.size() == 0);
    if (!line_idle) begin
      void'(m_line.pop_front());
    end else if (pre > 0) begin
      v = m_q.pop_front();
      sched_value(v);
    end
    if (out_val != m_last) begin
      m_last = out_val;
      if (pre < DEPTH) m_q.push_back(out_val);
      else m_ovf = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1'b1;
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("tx", {7'd0, tx_o}, {7'd0, (m_line.size() != 0) ? m_line[0] : 1'b1});
      check("busy", {7'd0, busy_o},
            {7'd0, (m_line.size() != 0) || (m_q.size() != 0)});
      check("overflow", {7'd0, overflow_o}, {7'd0, m_ovf});
      check("count", {5'd0, fifo_count_o}, 8'(m_q.size()));
    end
  end

  always @(negedge clk) if (!tx_o) saw_low = 1'b1;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy_o) break;
    end
    check("idle_timeout", {7'd0, busy_o}, 8'd0);
  endtask

  initial begin
    // Reset, then a long quiet stretch with out_val at zero
    reset   = 1'b1;
    out_val = 8'h00;
    cycles(3);
    reset = 1'b0;
    check("rst_tx", {7'd0, tx_o}, 8'd1);
    check("rst_count", {5'd0, fifo_count_o}, 8'd0);
    saw_low = 1'b0;
    cycles(2000);
    check("quiet_low", {7'd0, saw_low}, 8'd0);
    check("quiet_busy", {7'd0, busy_o}, 8'd0);
    check("quiet_ovf", {7'd0, overflow_o}, 8'd0);

    // Single frame of 0xA5
    @(negedge clk);
    out_val = 8'hA5;
    @(negedge clk);
    check("a5_count", {5'd0, fifo_count_o}, 8'd1);
    check("a5_busy", {7'd0, busy_o}, 8'd1);
    check("a5_tx0", {7'd0, tx_o}, 8'd1);
`ifndef OUT_UART_ASCII_HEX_EN
    begin
      logic [7:0] bits;
      bits = 8'b1010_0101;
      for (int i = 1; i <= 41; i++) begin
        @(negedge clk);
        if (i <= 4) check("a5_start", {7'd0, tx_o}, 8'd0);
        else if (i <= 36) check("a5_data", {7'd0, tx_o}, {7'd0, bits[(i-5)/4]});
        else check("a5_stop", {7'd0, tx_o}, 8'd1);
        if (i == 40) check("a5_busy_stop", {7'd0, busy_o}, 8'd1);
        if (i == 41) check("a5_busy_end", {7'd0, busy_o}, 8'd0);
      end
    end
`endif
    wait_idle(1000);

    // Unchanged value must not retransmit
    saw_low = 1'b0;
    cycles(1000);
    check("hold_low", {7'd0, saw_low}, 8'd0);

    // Six changes on consecutive cycles overflow a 4-deep queue
    for (int v = 1; v <= 6; v++) begin
      @(negedge clk);
      out_val = 8'(v);
    end
    @(negedge clk);
    check("ovf_set", {7'd0, overflow_o}, 8'd1);
    check("ovf_count", {5'd0, fifo_count_o}, 8'd4);
    wait_idle(3000);
    check("ovf_sticky", {7'd0, overflow_o}, 8'd1);

    // Reset in the middle of a frame with two values queued
    @(negedge clk);
    out_val = 8'h5A;
    @(negedge clk);
    out_val = 8'h11;
    @(negedge clk);
    out_val = 8'h22;
    cycles(12);
    check("mid_count", {5'd0, fifo_count_o}, 8'd2);
    reset   = 1'b1;
    out_val = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_tx", {7'd0, tx_o}, 8'd1);
    check("mid_rst_count", {5'd0, fifo_count_o}, 8'd0);
    check("mid_rst_ovf", {7'd0, overflow_o}, 8'd0);
    saw_low = 1'b0;
    cycles(200);
    check("mid_rst_quiet", {7'd0, saw_low}, 8'd0);

`ifdef OUT_UART_ASCII_HEX_EN
    // 0x3C goes out as '3' 'C' CR LF from a single pop
    @(negedge clk);
    out_val = 8'h3C;
    @(negedge clk);
    for (int i = 1; i <= 164; i++) begin
      @(negedge clk);
      if (i == 5) check("hex_b0", {7'd0, tx_o}, 8'd1);
      if (i == 13) check("hex_b2", {7'd0, tx_o}, 8'd0);
      if (i == 41) check("hex_gap", {7'd0, tx_o}, 8'd1);
      if (i == 42) check("hex_start2", {7'd0, tx_o}, 8'd0);
      if (i == 100) check("hex_pop_once", {5'd0, fifo_count_o}, 8'd0);
      if (i == 163) check("hex_busy", {7'd0, busy_o}, 8'd1);
      if (i == 164) check("hex_done", {7'd0, busy_o}, 8'd0);
    end
`endif

    cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
